// File: rtl/vga_fb_display.sv
// vga_fb_display: VGA timing generator scanning a double-buffered BPP framebuffer through a palette,
// with vertical scroll, vblank-synchronised page flip and a vblank interrupt on a write-only Avalon slave.
`timescale 1ns/1ps
module vga_fb_display #(
    parameter int BPP      = 1,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              chipselect,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       writedata,
    output logic              irq,
    output logic [7:0]        VGA_R,
    output logic [7:0]        VGA_G,
    output logic [7:0]        VGA_B,
    output logic              VGA_CLK,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic              VGA_BLANK_n,
    output logic              VGA_SYNC_n
);
    localparam int H_TOT      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int PPW        = 32 / BPP;
    localparam int LOG_PPW    = $clog2(PPW);
    localparam int WPL        = H_ACTIVE * BPP / 32;
    localparam int PAGE_WORDS = V_ACTIVE * WPL;
    localparam int FB_WORDS   = 2 * PAGE_WORDS;
    localparam int FA_W       = $clog2(FB_WORDS);
    localparam int HC_W       = $clog2(2 * H_TOT);
    localparam int VC_W       = $clog2(V_TOT);
    localparam int NPAL       = 1 << BPP;

    logic [HC_W-1:0]   hcount_q, hcount_d;
    logic [VC_W-1:0]   vcount_q, vcount_d;
    logic [HC_W-2:0]   x;
    logic              line_end, active, hs, vs, vblank_ev;
    logic              enable_q, page_req_q, flip_pending_q, page_act_q, irq_q;
    logic [8:0]        scroll_q, scroll_act_q;
    logic [31:0]       fb [FB_WORDS];
    logic [31:0]       fb_data_q, row_sum, row;
    logic [FA_W-1:0]   rd_addr;
    logic [LOG_PPW-1:0] sel_q;
    logic              s1_act_q, s1_hs_q, s1_vs_q, s1_clk_q;
    logic [23:0]       pal_q [NPAL];
    logic [23:0]       rgb_q;
    logic              hs_q, vs_q, blank_q, clk_q;
    logic              wr, fb_wr, ctrl_wr, ack_wr, scroll_wr, pal_wr;
    logic [ADDR_W-2:0] off;
    logic [BPP-1:0]    field;

    always_comb begin
        x         = hcount_q[HC_W-1:1];
        line_end  = 32'(hcount_q) == 2 * H_TOT - 1;
        hcount_d  = line_end ? '0 : hcount_q + 1'b1;
        vcount_d  = !line_end ? vcount_q : (32'(vcount_q) == V_TOT - 1 ? '0 : vcount_q + 1'b1);
        active    = 32'(x) < H_ACTIVE && 32'(vcount_q) < V_ACTIVE;
        hs        = !(32'(x) >= H_ACTIVE + H_FP && 32'(x) < H_ACTIVE + H_FP + H_SYNC);
        vs        = !(32'(vcount_q) >= V_ACTIVE + V_FP && 32'(vcount_q) < V_ACTIVE + V_FP + V_SYNC);
        vblank_ev = 32'(vcount_q) == V_ACTIVE && hcount_q == '0;
        row_sum   = 32'(vcount_q) + 32'(scroll_act_q);
        row       = row_sum >= V_ACTIVE ? row_sum - V_ACTIVE : row_sum;
        rd_addr   = active ? FA_W'(32'(page_act_q) * PAGE_WORDS + row * WPL + (32'(x) >> LOG_PPW)) : '0;
        off       = address[ADDR_W-2:0];
        wr        = chipselect & write;
        fb_wr     = wr && !address[ADDR_W-1] && 32'(off) < FB_WORDS;
        ctrl_wr   = wr && address[ADDR_W-1] && 32'(off) == 0;
        ack_wr    = wr && address[ADDR_W-1] && 32'(off) == 1;
        scroll_wr = wr && address[ADDR_W-1] && 32'(off) == 2 && 32'(writedata[8:0]) < V_ACTIVE;
        pal_wr    = wr && address[ADDR_W-1] && 32'(off) >= 'h100 && 32'(off) < 'h100 + NPAL;
        field     = BPP'(fb_data_q >> (32'(sel_q) * BPP));
    end

    // Framebuffer is plain synchronous RAM: its contents survive reset.
    always_ff @(posedge clk) begin
        if (fb_wr) fb[off[FA_W-1:0]] <= writedata;
        fb_data_q <= fb[rd_addr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hcount_q       <= '0;
            vcount_q       <= '0;
            enable_q       <= 1'b1;
            page_req_q     <= 1'b0;
            flip_pending_q <= 1'b0;
            page_act_q     <= 1'b0;
            scroll_q       <= '0;
            scroll_act_q   <= '0;
            irq_q          <= 1'b0;
            for (int i = 0; i < NPAL; i++) pal_q[i] <= (i == 0) ? 24'h000000 : 24'hFFFFFF;
            sel_q          <= '0;
            s1_act_q       <= 1'b0;
            s1_hs_q        <= 1'b0;
            s1_vs_q        <= 1'b0;
            s1_clk_q       <= 1'b0;
            rgb_q          <= '0;
            hs_q           <= 1'b0;
            vs_q           <= 1'b0;
            blank_q        <= 1'b0;
            clk_q          <= 1'b0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            if (ctrl_wr) begin
                enable_q   <= writedata[0];
                page_req_q <= writedata[1];
            end
            // A CTRL write coinciding with vblank start stays pending for the next one.
            flip_pending_q <= ctrl_wr | (flip_pending_q & ~vblank_ev);
            if (vblank_ev) begin
                if (flip_pending_q) page_act_q <= page_req_q;
                scroll_act_q <= scroll_q;
            end
            if (scroll_wr) scroll_q <= writedata[8:0];
            irq_q <= vblank_ev | (irq_q & ~ack_wr);
            if (pal_wr) pal_q[off[BPP-1:0]] <= writedata[23:0];
            sel_q    <= x[LOG_PPW-1:0];
            s1_act_q <= active;
            s1_hs_q  <= hs;
            s1_vs_q  <= vs;
            s1_clk_q <= hcount_q[0];
            rgb_q    <= (s1_act_q && enable_q) ? pal_q[field] : '0;
            hs_q     <= s1_hs_q;
            vs_q     <= s1_vs_q;
            blank_q  <= s1_act_q;
            clk_q    <= s1_clk_q;
        end
    end

    assign irq                   = irq_q;
    assign {VGA_R, VGA_G, VGA_B} = rgb_q;
    assign VGA_HS                = hs_q;
    assign VGA_VS                = vs_q;
    assign VGA_BLANK_n           = blank_q;
    assign VGA_CLK               = clk_q;
    assign VGA_SYNC_n            = 1'b0;
endmodule
